// File: rtl/exc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exc_sequencer
//  Description : Exception/interrupt sequencer for a simple in-order pipeline.
//                Synchronizes an external IRQ, prioritizes it over illegal
//                instructions, saves return PC/status, drives flush and
//                next-PC select, and counts taken exceptions (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_sequencer #(
  parameter logic [63:0] VECTOR_ADDR = 64'h0000_0000_0000_00D8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ExtIRQ,
  input  logic        NotAnInstr,
  input  logic        ERet,
  input  logic [63:0] pc_in,
  output logic        Flush,
  output logic [1:0]  PCSel,
  output logic [63:0] ELR,
  output logic [3:0]  ESR,
  output logic        ExtIAck,
  output logic        InHandler,
  output logic [7:0]  ExcCount
);

  localparam logic [3:0] c_CAUSE_IRQ    = 4'b0001;
  localparam logic [3:0] c_CAUSE_ILLEGAL = 4'b0010;
  localparam logic [3:0] c_CAUSE_DFAULT = 4'b0011;

  localparam logic [1:0] c_PC_SEQ = 2'b00;
  localparam logic [1:0] c_PC_VEC = 2'b01;
  localparam logic [1:0] c_PC_ELR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TAKE    = 3'd1,
    S_HANDLER = 3'd2,
    S_RET     = 3'd3,
    S_LOCK    = 3'd4
  } state_t;

  // The vector is fetched as an instruction address, so it must be aligned.
  if (VECTOR_ADDR[1:0] != 2'b00) begin : g_vec_align_check
    $error("exc_sequencer: VECTOR_ADDR must be 4-byte aligned");
  end

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic        irq_pend_q, irq_pend_d;
  logic [63:0] elr_q, elr_d;
  logic [3:0]  esr_q, esr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        irq_rise;
  logic        irq_req;
  logic [7:0]  cnt_inc;

  // Rising edge of the synchronized request; it also counts as pending in the
  // same cycle so an idle core takes the interrupt one cycle sooner.
  assign irq_rise = sync2_q & ~sync3_q;
  assign irq_req  = irq_pend_q | irq_rise;
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= ExtIRQ;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Pending flag: a new edge wins over the acknowledge in the same cycle.
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (irq_rise) begin
      irq_pend_d = 1'b1;
    end else if (ExtIAck) begin
      irq_pend_d = 1'b0;
    end
  end

  // State, saved context and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      irq_pend_q <= 1'b0;
      elr_q      <= 64'd0;
      esr_q      <= 4'd0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
      elr_q      <= elr_d;
      esr_q      <= esr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic; context is captured on entry to TAKE so it is visible
  // during the TAKE cycle itself.
  always_comb begin
    state_d = state_q;
    elr_d   = elr_q;
    esr_d   = esr_q;
    cnt_d   = cnt_q;
    Flush   = 1'b0;
    PCSel   = c_PC_SEQ;
    ExtIAck = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (irq_req) begin
          state_d = S_TAKE;
          elr_d   = pc_in;
          esr_d   = c_CAUSE_IRQ;
          cnt_d   = cnt_inc;
        end else if (NotAnInstr) begin
          state_d = S_TAKE;
          elr_d   = pc_in;
          esr_d   = c_CAUSE_ILLEGAL;
          cnt_d   = cnt_inc;
        end
      end
      S_TAKE: begin
        Flush   = 1'b1;
        PCSel   = c_PC_VEC;
        ExtIAck = (esr_q == c_CAUSE_IRQ);
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        if (ERet) begin
          state_d = S_RET;
        end else if (NotAnInstr) begin
          state_d = S_LOCK;
          esr_d   = c_CAUSE_DFAULT;
        end
      end
      S_RET: begin
        Flush   = 1'b1;
        PCSel   = c_PC_ELR;
        state_d = S_IDLE;
      end
      S_LOCK: begin
        Flush = 1'b1;
        PCSel = c_PC_VEC;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ELR       = elr_q;
  assign ESR       = esr_q;
  assign ExcCount  = cnt_q;
  assign InHandler = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_exc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_sequencer
//  Description : Cycle-by-cycle vector bench for exc_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_sequencer;

  typedef struct {
    logic        irq;
    logic        nai;
    logic        eret;
    logic [63:0] pc;
    logic        flush;
    logic [1:0]  pcsel;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic        ack;
    logic        inh;
    logic [7:0]  cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ExtIRQ;
  logic        NotAnInstr;
  logic        ERet;
  logic [63:0] pc_in;
  logic        Flush;
  logic [1:0]  PCSel;
  logic [63:0] ELR;
  logic [3:0]  ESR;
  logic        ExtIAck;
  logic        InHandler;
  logic [7:0]  ExcCount;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t exp_q[$];
  vec_t tbl[45];

  exc_sequencer #(.VECTOR_ADDR(64'h0000_0000_0000_00D8)) dut (
    .clk       (clk),
    .reset     (reset),
    .ExtIRQ    (ExtIRQ),
    .NotAnInstr(NotAnInstr),
    .ERet      (ERet),
    .pc_in     (pc_in),
    .Flush     (Flush),
    .PCSel     (PCSel),
    .ELR       (ELR),
    .ESR       (ESR),
    .ExtIAck   (ExtIAck),
    .InHandler (InHandler),
    .ExcCount  (ExcCount)
  );

  always #5 clk = ~clk;

  function automatic vec_t V(input logic irq, input logic nai, input logic eret,
                             input logic [63:0] pc, input logic fl, input logic [1:0] ps,
                             input logic [63:0] elr, input logic [3:0] esr,
                             input logic ack, input logic inh, input logic [7:0] cnt);
    vec_t v;
    v.irq = irq; v.nai = nai; v.eret = eret; v.pc = pc;
    v.flush = fl; v.pcsel = ps; v.elr = elr; v.esr = esr;
    v.ack = ack; v.inh = inh; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input vec_t e, input string nm);
    n_vec++;
    if (Flush !== e.flush || PCSel !== e.pcsel || ELR !== e.elr || ESR !== e.esr ||
        ExtIAck !== e.ack || InHandler !== e.inh || ExcCount !== e.cnt) begin
      n_err++;
      $display("FAIL %s: got flush=%0d pcsel=%0d elr=%h esr=%h ack=%0d inh=%0d cnt=%0d ; want flush=%0d pcsel=%0d elr=%h esr=%h ack=%0d inh=%0d cnt=%0d",
               nm, Flush, PCSel, ELR, ESR, ExtIAck, InHandler, ExcCount,
               e.flush, e.pcsel, e.elr, e.esr, e.ack, e.inh, e.cnt);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input vec_t v, input string nm);
    ExtIRQ     = v.irq;
    NotAnInstr = v.nai;
    ERet       = v.eret;
    pc_in      = v.pc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check(exp_q.pop_front(), nm);
  endtask

  initial begin
    // Illegal instruction taken, handled, returned; ERet ignored in IDLE.
    tbl[0]  = V(0,1,0,64'h40,  1,2'b01,64'h40,4'h2,0,1,8'd1);
    tbl[1]  = V(0,0,0,64'h44,  0,2'b00,64'h40,4'h2,0,1,8'd1);
    tbl[2]  = V(0,0,0,64'h48,  0,2'b00,64'h40,4'h2,0,1,8'd1);
    tbl[3]  = V(0,0,1,64'h4C,  1,2'b10,64'h40,4'h2,0,1,8'd1);
    tbl[4]  = V(0,0,0,64'h0,   0,2'b00,64'h40,4'h2,0,0,8'd1);
    tbl[5]  = V(0,0,1,64'h0,   0,2'b00,64'h40,4'h2,0,0,8'd1);
    // IRQ: edge passes two sync flops, TAKE on the third edge with ack.
    tbl[6]  = V(1,0,0,64'h100, 0,2'b00,64'h40,4'h2,0,0,8'd1);
    tbl[7]  = V(1,0,0,64'h100, 0,2'b00,64'h40,4'h2,0,0,8'd1);
    tbl[8]  = V(1,0,0,64'h100, 1,2'b01,64'h100,4'h1,1,1,8'd2);
    tbl[9]  = V(0,0,0,64'h104, 0,2'b00,64'h100,4'h1,0,1,8'd2);
    tbl[10] = V(0,0,1,64'h108, 1,2'b10,64'h100,4'h1,0,1,8'd2);
    tbl[11] = V(0,0,0,64'h0,   0,2'b00,64'h100,4'h1,0,0,8'd2);
    tbl[12] = V(0,0,0,64'h0,   0,2'b00,64'h100,4'h1,0,0,8'd2);
    // IRQ edge and illegal instruction in the same cycle: IRQ wins.
    tbl[13] = V(1,0,0,64'h0,   0,2'b00,64'h100,4'h1,0,0,8'd2);
    tbl[14] = V(1,0,0,64'h0,   0,2'b00,64'h100,4'h1,0,0,8'd2);
    tbl[15] = V(1,1,0,64'h200, 1,2'b01,64'h200,4'h1,1,1,8'd3);
    tbl[16] = V(0,0,0,64'h204, 0,2'b00,64'h200,4'h1,0,1,8'd3);
    tbl[17] = V(0,0,1,64'h0,   1,2'b10,64'h200,4'h1,0,1,8'd3);
    tbl[18] = V(0,0,0,64'h0,   0,2'b00,64'h200,4'h1,0,0,8'd3);
    // Squashed illegal instruction re-detected after return.
    tbl[19] = V(0,1,0,64'h200, 1,2'b01,64'h200,4'h2,0,1,8'd4);
    tbl[20] = V(0,0,0,64'h0,   0,2'b00,64'h200,4'h2,0,1,8'd4);
    tbl[21] = V(0,0,1,64'h0,   1,2'b10,64'h200,4'h2,0,1,8'd4);
    tbl[22] = V(0,0,0,64'h0,   0,2'b00,64'h200,4'h2,0,0,8'd4);
    // IRQ arriving during HANDLER is deferred until after RET + one IDLE.
    tbl[23] = V(0,1,0,64'h300, 1,2'b01,64'h300,4'h2,0,1,8'd5);
    tbl[24] = V(1,0,0,64'h0,   0,2'b00,64'h300,4'h2,0,1,8'd5);
    tbl[25] = V(1,0,0,64'h0,   0,2'b00,64'h300,4'h2,0,1,8'd5);
    tbl[26] = V(1,0,0,64'h0,   0,2'b00,64'h300,4'h2,0,1,8'd5);
    tbl[27] = V(1,0,1,64'h0,   1,2'b10,64'h300,4'h2,0,1,8'd5);
    tbl[28] = V(1,0,0,64'h0,   0,2'b00,64'h300,4'h2,0,0,8'd5);
    tbl[29] = V(1,0,0,64'h308, 1,2'b01,64'h308,4'h1,1,1,8'd6);
    tbl[30] = V(0,0,0,64'h0,   0,2'b00,64'h308,4'h1,0,1,8'd6);
    tbl[31] = V(0,0,1,64'h0,   1,2'b10,64'h308,4'h1,0,1,8'd6);
    tbl[32] = V(0,0,0,64'h0,   0,2'b00,64'h308,4'h1,0,0,8'd6);
    // Double fault locks up; ERet and IRQ have no effect.
    tbl[33] = V(0,1,0,64'h400, 1,2'b01,64'h400,4'h2,0,1,8'd7);
    tbl[34] = V(0,0,0,64'h0,   0,2'b00,64'h400,4'h2,0,1,8'd7);
    tbl[35] = V(0,1,0,64'h404, 1,2'b01,64'h400,4'h3,0,1,8'd7);
    tbl[36] = V(0,0,1,64'h0,   1,2'b01,64'h400,4'h3,0,1,8'd7);
    tbl[37] = V(1,0,0,64'h0,   1,2'b01,64'h400,4'h3,0,1,8'd7);
    tbl[38] = V(1,0,0,64'h0,   1,2'b01,64'h400,4'h3,0,1,8'd7);
    // After reset release with ExtIRQ still high: fresh sync edge, then TAKE.
    tbl[39] = V(1,0,0,64'h0,   0,2'b00,64'h0,4'h0,0,0,8'd0);
    tbl[40] = V(1,0,0,64'h0,   0,2'b00,64'h0,4'h0,0,0,8'd0);
    tbl[41] = V(1,0,0,64'h500, 1,2'b01,64'h500,4'h1,1,1,8'd1);
    tbl[42] = V(0,0,0,64'h0,   0,2'b00,64'h500,4'h1,0,1,8'd1);
    tbl[43] = V(0,0,1,64'h0,   1,2'b10,64'h500,4'h1,0,1,8'd1);
    tbl[44] = V(0,0,0,64'h0,   0,2'b00,64'h500,4'h1,0,0,8'd1);

    reset = 1'b0; ExtIRQ = 1'b0; NotAnInstr = 1'b0; ERet = 1'b0; pc_in = 64'd0;
    #2;
    check(V(0,0,0,0, 0,2'b00,64'h0,4'h0,0,0,8'd0), "reset_state");
    #1 reset = 1'b1;

    for (int i = 0; i < 39; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a cycle while locked.
    #3 reset = 1'b0;
    #1 check(V(0,0,0,0, 0,2'b00,64'h0,4'h0,0,0,8'd0), "async_reset_from_lock");
    #2 reset = 1'b1;

    for (int i = 39; i < 45; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Saturation: 260 illegal/ERet round trips starting from a count of 1.
    begin
      int          e;
      logic [63:0] pc;
      e = 1;
      for (int k = 0; k < 260; k++) begin
        pc = 64'h1000 + 64'(k * 4);
        e  = (e < 255) ? e + 1 : 255;
        step(V(0,1,0,pc,  1,2'b01,pc,4'h2,0,1,8'(e)), $sformatf("sat%0d_take", k));
        step(V(0,0,0,0,   0,2'b00,pc,4'h2,0,1,8'(e)), $sformatf("sat%0d_hdl", k));
        step(V(0,0,1,0,   1,2'b10,pc,4'h2,0,1,8'(e)), $sformatf("sat%0d_ret", k));
        step(V(0,0,0,0,   0,2'b00,pc,4'h2,0,0,8'(e)), $sformatf("sat%0d_idle", k));
      end
      n_vec++;
      if (ExcCount !== 8'hFF) begin
        n_err++;
        $display("FAIL sat_final: got cnt=%h want cnt=ff", ExcCount);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exc_sequencer.md
EXC_SEQUENCER -- requirements
Module: exc_sequencer

Interface
REQ-001 Parameter VECTOR_ADDR, default 64'h0000_0000_0000_00D8, exception vector address driven on PC redirect.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserted (0) forces reset state immediately regardless of clk.
REQ-004 ExtIRQ  input  1  external interrupt request, asynchronous level, held by device until ExtIAck seen.
REQ-005 NotAnInstr  input  1  decode flags current instruction illegal, synchronous, valid one cycle.
REQ-006 ERet  input  1  decode flags ERET instruction, synchronous.
REQ-007 pc_in  input  64  PC of instruction in decode.
REQ-008 Flush  output  1  squash younger pipeline stages this cycle.
REQ-009 PCSel  output  2  next-PC select: 00 sequential, 01 VECTOR_ADDR, 10 ELR.
REQ-010 ELR  output  64  saved exception return address.
REQ-011 ESR  output  4  saved exception status.
REQ-012 ExtIAck  output  1  one-cycle acknowledge pulse to interrupting device.
REQ-013 InHandler  output  1  high while handler executing (TAKE, HANDLER, RET, LOCK).
REQ-014 ExcCount  output  8  count of exceptions taken, saturating.

Function
REQ-015 ExtIRQ SHALL pass a 2-flop synchronizer; a rising edge of the synchronized signal SHALL set irq_pend.
REQ-016 irq_pend SHALL clear only in the cycle ExtIAck is asserted; a set and clear in the same cycle SHALL leave irq_pend set.
REQ-017 FSM states: IDLE, TAKE, HANDLER, RET, LOCK.
REQ-018 IDLE: irq_pend -> TAKE with cause 0001; else NotAnInstr -> TAKE with cause 0010; else stay; ERet in IDLE SHALL be ignored.
REQ-019 IRQ SHALL have priority over NotAnInstr when both present in IDLE; the illegal instruction is squashed and re-detected after return.
REQ-020 TAKE (exactly one cycle): ELR <= pc_in, ESR <= cause, Flush=1, PCSel=01, ExtIAck=1 iff cause 0001, ExcCount += 1 unless 255; next HANDLER.
REQ-021 HANDLER: ERet -> RET; NotAnInstr (ERet low) -> LOCK with ESR <= 0011; irq_pend SHALL be held, not taken (no nesting).
REQ-022 RET (exactly one cycle): Flush=1, PCSel=10; ELR/ESR unchanged; next IDLE.
REQ-023 IRQ pending at RET SHALL be taken in the cycle after IDLE is re-entered (IDLE->TAKE, one IDLE cycle minimum).
REQ-024 LOCK: terminal; Flush=1, PCSel=01 held every cycle; left only via reset.
REQ-025 Flush, PCSel, ExtIAck SHALL be combinational from state; 0/00/0 in IDLE and HANDLER.
REQ-026 Latency: NotAnInstr in IDLE -> Flush/PCSel=01 next cycle; ExtIRQ rising edge -> TAKE no later than 3 cycles later from IDLE.
REQ-027 ExcCount SHALL saturate at 8'hFF, never wrap.

Reset
REQ-028 On reset=0: state IDLE, irq_pend 0, synchronizer 0, ELR 0, ESR 0000, ExcCount 0, Flush 0, PCSel 00, ExtIAck 0, InHandler 0.
REQ-029 Reset asserted mid-TAKE/HANDLER/RET/LOCK SHALL abandon the exception with no ExtIAck pulse; a still-high ExtIRQ after release SHALL be re-detected only on a new synchronized rising edge.

Verification
REQ-030 Illegal: IDLE, pc_in=64'h40, NotAnInstr 1 cycle -> next cycle Flush=1, PCSel=01, ELR=64'h40, ESR=0010, ExcCount=1, ExtIAck=0.
REQ-031 IRQ: ExtIRQ rises, pc_in=64'h100 -> TAKE within 3 cycles, ExtIAck one-cycle pulse, ESR=0001; ERet later -> one cycle PCSel=10, Flush=1, then IDLE.
REQ-032 Simultaneous: irq_pend set and NotAnInstr same IDLE cycle -> ESR=0001, ExtIAck=1; ExcCount +1 only.
REQ-033 Deferred: ExtIRQ edge during HANDLER -> no ExtIAck until after RET; then IDLE 1 cycle, TAKE, ESR=0001.
REQ-034 Double fault: NotAnInstr in HANDLER -> LOCK, ESR=0011, Flush=1 each cycle; reset=0 -> all REQ-028 values immediately.
REQ-035 Saturation: 260 illegal/ERet pairs -> ExcCount=8'hFF.
